uart16550_wb_master: RTL and testbench

UART16550_WB_MASTER -- requirements
Module: uart16550_wb_master

---
 rtl/uart16550_wb_pkg.sv | 60 ++++++
 rtl/uart16550_wb_master_wb_single_access.sv | 111 +++++++++++
 rtl/uart16550_wb_master.sv | 159 +++++++++++++++
 tb/tb_uart16550_wb_master.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart16550_wb_pkg.sv
// Shared definitions for the 16550 Wishbone master.
// Holds the 16550 register map, the LSR/LCR bit positions the master needs,
// the controller state enumeration and the table of initialisation writes.
package uart16550_wb_pkg;

  // 16550 register addresses (DLAB selects the aliased meanings of 0 and 1).
  localparam logic [2:0] ADR_THR = 3'd0;
  localparam logic [2:0] ADR_DLL = 3'd0;
  localparam logic [2:0] ADR_IER = 3'd1;
  localparam logic [2:0] ADR_DLM = 3'd1;
  localparam logic [2:0] ADR_FCR = 3'd2;
  localparam logic [2:0] ADR_LCR = 3'd3;
  localparam logic [2:0] ADR_LSR = 3'd5;

  // LSR: transmit holding register empty.
  localparam int unsigned LSR_THRE = 5;
  // LCR: divisor latch access bit.
  localparam int unsigned LCR_DLAB = 7;

  // FCR value written at init: enable FIFOs and clear both.
  localparam logic [7:0] FCR_INIT = 8'h07;

  // Number of writes in the initialisation sequence.
  localparam int unsigned INIT_STEPS = 6;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_POLL  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] adr;
    logic [7:0] dat;
  } wb_wr_t;

  // Address/data of initialisation write number `step`.
  function automatic wb_wr_t init_access(input logic [2:0]  step,
                                         input logic [15:0] divisor,
                                         input logic [7:0]  lcr);
    wb_wr_t     w;
    logic [7:0] dlab_set;
    logic [7:0] dlab_clr;
    dlab_set = lcr;
    dlab_set[LCR_DLAB] = 1'b1;
    dlab_clr = lcr;
    dlab_clr[LCR_DLAB] = 1'b0;
    case (step)
      3'd0:    begin w.adr = ADR_LCR; w.dat = dlab_set;       end
      3'd1:    begin w.adr = ADR_DLL; w.dat = divisor[7:0];   end
      3'd2:    begin w.adr = ADR_DLM; w.dat = divisor[15:8];  end
      3'd3:    begin w.adr = ADR_LCR; w.dat = dlab_clr;       end
      3'd4:    begin w.adr = ADR_FCR; w.dat = FCR_INIT;       end
      default: begin w.adr = ADR_IER; w.dat = 8'h00;          end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/uart16550_wb_master_wb_single_access.sv
// wb_single_access: one Wishbone classic single access at a time.
// Latches address/data/we when req_i is seen while idle, raises cyc/stb on
// the following edge, and drops them on the edge a termination is sampled.
// Retry re-issues the identical access after one idle cycle; error or a
// TIMEOUT-cycle stall aborts it (TIMEOUT=0 waits forever).
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_i, adr_i/dat_i/we_i  access request from the controller
//   wb_ack_i/err_i/rty_i     terminations from the slave
//   wb_cyc_o..wb_we_o        Wishbone master outputs
//   busy_o                   access in flight or retry pending
//   ok_o                     access acknowledged this cycle
//   abort_o                  access aborted (error or timeout) this cycle
module wb_single_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  input  logic       we_i,
  input  logic       wb_ack_i,
  input  logic       wb_err_i,
  input  logic       wb_rty_i,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       busy_o,
  output logic       ok_o,
  output logic       abort_o
);

  logic        stb_q, stb_d;
  logic        retry_q, retry_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic        we_q, we_d;
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    stb_d   = stb_q;
    retry_d = retry_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    ok_o    = 1'b0;
    abort_o = 1'b0;
    if (stb_q) begin
      // Priority: err, then ack, then rty, then timeout.
      if (wb_err_i) begin
        abort_o = 1'b1;
        stb_d   = 1'b0;
      end else if (wb_ack_i) begin
        ok_o  = 1'b1;
        stb_d = 1'b0;
      end else if (wb_rty_i) begin
        stb_d   = 1'b0;
        retry_d = 1'b1;
      end else if (timeout_hit) begin
        abort_o = 1'b1;
        stb_d   = 1'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else if (retry_q) begin
      // Address/data/we are still latched, so the re-issue is identical.
      stb_d   = 1'b1;
      retry_d = 1'b0;
      cnt_d   = '0;
    end else if (req_i) begin
      stb_d = 1'b1;
      adr_d = adr_i;
      dat_d = dat_i;
      we_d  = we_i;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q   <= 1'b0;
      retry_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stb_q   <= stb_d;
      retry_q <= retry_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_cyc_o = stb_q;
  assign wb_stb_o = stb_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign busy_o   = stb_q | retry_q;

endmodule

// File: rtl/uart16550_wb_master.sv
// uart16550_wb_master: programs a 16550 over Wishbone after reset, then
// transmits bytes by polling LSR.THRE and writing THR.
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-low reset
//   tx_data_i/tx_valid_i        byte to send, accepted when tx_ready_o=1
//   tx_ready_o                  idle and initialised
//   wb_adr_o..wb_bte_o          Wishbone classic master outputs
//   wb_dat_i, wb_ack/err/rty_i  Wishbone slave response
//   init_done_o                 init sequence finished
//   err_o                       sticky: some access errored or timed out
module uart16550_wb_master
  import uart16550_wb_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic [2:0] wb_cti_o,
  output logic [1:0] wb_bte_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       wb_err_i,
  input  logic       wb_rty_i,
  output logic       init_done_o,
  output logic       err_o
);

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       init_done_q, init_done_d;
  logic       err_q, err_d;
  logic [7:0] byte_q, byte_d;
  logic       go_q;

  logic       req;
  logic [2:0] req_adr;
  logic [7:0] req_dat;
  logic       req_we;
  logic       acc_busy, acc_ok, acc_abort;
  logic       lsr_thre;
  logic       unused_dat;
  wb_wr_t     init_wr;

  assign init_wr    = init_access(step_q, DIVISOR, LCR_VAL);
  assign lsr_thre   = wb_dat_i[LSR_THRE];
  assign unused_dat = ^{wb_dat_i[7:6], wb_dat_i[4:0]};
  assign tx_ready_o = (state_q == ST_IDLE) && init_done_q;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    err_d       = err_q | acc_abort;
    byte_d      = byte_q;
    req         = 1'b0;
    req_adr     = '0;
    req_dat     = '0;
    req_we      = 1'b0;
    case (state_q)
      ST_INIT: begin
        // go_q holds off the first request one cycle after reset release.
        req     = go_q && !acc_busy;
        req_adr = init_wr.adr;
        req_dat = init_wr.dat;
        req_we  = 1'b1;
        if (acc_ok || acc_abort) begin
          if (step_q == 3'(INIT_STEPS - 1)) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      ST_IDLE: begin
        if (tx_valid_i && tx_ready_o) begin
          byte_d  = tx_data_i;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        // A not-ready LSR just stays here and re-requests once idle.
        req     = !acc_busy;
        req_adr = ADR_LSR;
        if (acc_abort) begin
          state_d = ST_IDLE;
        end else if (acc_ok && lsr_thre) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        req     = !acc_busy;
        req_adr = ADR_THR;
        req_dat = byte_q;
        req_we  = 1'b1;
        if (acc_ok || acc_abort) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= ST_INIT;
      step_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      byte_q      <= '0;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      byte_q      <= byte_d;
      go_q        <= 1'b1;
    end
  end

  wb_single_access #(
    .TIMEOUT(TIMEOUT)
  ) u_access (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_i),
    .req_i    (req),
    .adr_i    (req_adr),
    .dat_i    (req_dat),
    .we_i     (req_we),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_we_o  (wb_we_o),
    .busy_o   (acc_busy),
    .ok_o     (acc_ok),
    .abort_o  (acc_abort)
  );

  assign wb_cti_o    = 3'b000;
  assign wb_bte_o    = 2'b00;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart16550_wb_master.sv
module tb_uart16550_wb_master;

  localparam logic [15:0] DIV = 16'd27;
  localparam logic [7:0]  LCR = 8'h03;
  localparam int unsigned TMO = 8;

  localparam int K_ACK = 0, K_RTY = 1, K_ERR = 2, K_SILENT = 3, K_ERRACK = 4, K_ERRRTY = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [2:0] adr_o;
  logic [7:0] dat_o;
  logic       we_o, cyc_o, stb_o;
  logic [2:0] cti_o;
  logic [1:0] bte_o;
  logic [7:0] dat_i = '0;
  logic       ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic       init_done, err_flag;

  always #5 clk = ~clk;

  uart16550_wb_master #(
    .DIVISOR(DIV),
    .LCR_VAL(LCR),
    .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .wb_adr_o   (adr_o),
    .wb_dat_o   (dat_o),
    .wb_we_o    (we_o),
    .wb_cyc_o   (cyc_o),
    .wb_stb_o   (stb_o),
    .wb_cti_o   (cti_o),
    .wb_bte_o   (bte_o),
    .wb_dat_i   (dat_i),
    .wb_ack_i   (ack),
    .wb_err_i   (err),
    .wb_rty_i   (rty),
    .init_done_o(init_done),
    .err_o      (err_flag)
  );

  typedef struct {
    int         kind;
    int         wt;
    logic [7:0] rd;
  } resp_t;

  typedef struct {
    logic [2:0] adr;
    logic [7:0] dat;
    logic       we;
    int         gap;
    int         dur;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_log[$];
  resp_t cur;
  int    wcnt = 0;
  int    idle_run = 100;
  bit    in_acc = 1'b0;
  int    total = 0, bad = 0, proto_viol = 0;

  // Slave model: answers each access from resp_q (default: ack, LSR=THRE),
  // logs every access and watches bus stability.
  initial begin
    forever begin
      @(negedge clk);
      ack = 1'b0; err = 1'b0; rty = 1'b0;
      if (stb_o) begin
        if (!in_acc) begin
          acc_t e;
          in_acc = 1'b1;
          if (resp_q.size() > 0) cur = resp_q.pop_front();
          else begin cur.kind = K_ACK; cur.wt = 0; cur.rd = 8'h20; end
          wcnt = 0;
          e.adr = adr_o; e.dat = dat_o; e.we = we_o; e.gap = idle_run; e.dur = 0;
          acc_log.push_back(e);
        end else begin
          if (adr_o !== acc_log[acc_log.size()-1].adr || dat_o !== acc_log[acc_log.size()-1].dat ||
              we_o !== acc_log[acc_log.size()-1].we) proto_viol++;
        end
        acc_log[acc_log.size()-1].dur = acc_log[acc_log.size()-1].dur + 1;
        if (cyc_o !== 1'b1) proto_viol++;
        dat_i = cur.rd;
        if (cur.kind != K_SILENT) begin
          if (wcnt == cur.wt) begin
            case (cur.kind)
              K_ACK:    ack = 1'b1;
              K_RTY:    rty = 1'b1;
              K_ERR:    err = 1'b1;
              K_ERRACK: begin err = 1'b1; ack = 1'b1; end
              default:  begin err = 1'b1; rty = 1'b1; end
            endcase
          end else wcnt++;
        end
        idle_run = 0;
      end else begin
        in_acc = 1'b0;
        idle_run++;
        if (cyc_o !== 1'b0) proto_viol++;
      end
      if (cti_o !== 3'b000 || bte_o !== 2'b00) proto_viol++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers (no checking inside).
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    @(negedge clk);
    tx_data = b; tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin @(negedge clk); n++; end
    ok = tx_ready;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready(input int maxc, output bit ok, output bit prev_stb);
    bit p = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
      p = stb_o;
    end
    prev_stb = p;
  endtask

  task automatic wait_init(input int maxc, output bit ok, output bit prev_stb);
    bit p = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (init_done) begin ok = 1'b1; break; end
      p = stb_o;
    end
    prev_stb = p;
  endtask

  task automatic release_reset();
    resp_q.delete();
    acc_log.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] exp_init_dat(input int i);
    case (i)
      0: return 8'h80 | LCR;
      1: return DIV[7:0];
      2: return DIV[15:8];
      3: return LCR & 8'h7F;
      4: return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] exp_init_adr(input int i);
    case (i)
      0, 3: return 3'd3;
      1: return 3'd0;
      4: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({stb_o, cyc_o, we_o, adr_o, dat_o, tx_ready, init_done, err_flag} !== '0) begin
      bad++; $display("FAIL reset_state: got %b required all zero",
                      {stb_o, cyc_o, we_o, adr_o, dat_o, tx_ready, init_done, err_flag});
    end
    release_reset();
    @(posedge clk); #1;
    total++;
    if (stb_o !== 1'b0) begin bad++; $display("FAIL reset_edge1_stb: got %b required 0", stb_o); end
    @(posedge clk); #1;
    total++;
    if (stb_o !== 1'b1 || adr_o !== 3'd3 || dat_o !== (8'h80 | LCR) || we_o !== 1'b1) begin
      bad++; $display("FAIL reset_edge2_first_write: stb=%b adr=%0d dat=%h we=%b required 1 3 %h 1",
                      stb_o, adr_o, dat_o, we_o, 8'h80 | LCR);
    end
  endtask

  task automatic test_init();
    bit ok, ps;
    wait_init(200, ok, ps);
    total++;
    if (!ok) begin bad++; $display("FAIL init_done_timeout: init_done=%b required 1", init_done); end
    total++;
    if (ps !== 1'b1 || stb_o !== 1'b0) begin
      bad++; $display("FAIL init_done_timing: prev_stb=%b stb=%b required 1 0", ps, stb_o);
    end
    total++;
    if (acc_log.size() != 6) begin
      bad++; $display("FAIL init_count: got %0d required 6", acc_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (acc_log[i].adr !== exp_init_adr(i) || acc_log[i].dat !== exp_init_dat(i) || acc_log[i].we !== 1'b1) begin
          bad++; $display("FAIL init_write%0d: got adr=%0d dat=%h we=%b required adr=%0d dat=%h we=1",
                          i, acc_log[i].adr, acc_log[i].dat, acc_log[i].we, exp_init_adr(i), exp_init_dat(i));
        end
      end
    end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || err_flag !== 1'b0 || init_done !== 1'b1) begin
      bad++; $display("FAIL post_init_flags: ready=%b err=%b done=%b required 1 0 1", tx_ready, err_flag, init_done);
    end
  endtask

  task automatic test_send_41();
    bit ok, ps;
    acc_log.delete();
    resp_q.push_back('{K_ACK, 0, 8'h60});
    send_byte(8'h41, ok);
    total++;
    if (!ok || stb_o !== 1'b0 || tx_ready !== 1'b0) begin
      bad++; $display("FAIL capture_41: ok=%b stb=%b ready=%b required 1 0 0", ok, stb_o, tx_ready);
    end
    @(posedge clk); #1;
    total++;
    if (stb_o !== 1'b1 || adr_o !== 3'd5 || we_o !== 1'b0) begin
      bad++; $display("FAIL lsr_issue_41: stb=%b adr=%0d we=%b required 1 5 0", stb_o, adr_o, we_o);
    end
    wait_ready(100, ok, ps);
    total++;
    if (!ok || ps !== 1'b1) begin bad++; $display("FAIL ready_after_41: ok=%b prev_stb=%b required 1 1", ok, ps); end
    total++;
    if (acc_log.size() != 2 || acc_log[0].adr !== 3'd5 || acc_log[0].we !== 1'b0 ||
        acc_log[1].adr !== 3'd0 || acc_log[1].dat !== 8'h41 || acc_log[1].we !== 1'b1) begin
      bad++; $display("FAIL seq_41: got %0d accesses required LSR read then THR write 41", acc_log.size());
    end
  endtask

  task automatic test_poll_busy();
    bit ok, ps;
    acc_log.delete();
    resp_q.push_back('{K_ACK, 0, 8'h00});
    resp_q.push_back('{K_ACK, 0, 8'h00});
    resp_q.push_back('{K_ACK, 0, 8'h20});
    send_byte(8'h42, ok);
    wait_ready(100, ok, ps);
    total++;
    if (!ok) begin bad++; $display("FAIL ready_after_42: got 0 required 1"); end
    total++;
    if (acc_log.size() != 4) begin
      bad++; $display("FAIL poll_count_42: got %0d required 4", acc_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (acc_log[i].adr !== 3'd5 || acc_log[i].we !== 1'b0 || (i > 0 && acc_log[i].gap != 1)) begin
          bad++; $display("FAIL poll_read%0d: adr=%0d we=%b gap=%0d required 5 0 gap 1",
                          i, acc_log[i].adr, acc_log[i].we, acc_log[i].gap);
        end
      end
      total++;
      if (acc_log[3].adr !== 3'd0 || acc_log[3].dat !== 8'h42 || acc_log[3].we !== 1'b1) begin
        bad++; $display("FAIL poll_write_42: adr=%0d dat=%h required 0 42", acc_log[3].adr, acc_log[3].dat);
      end
    end
  endtask

  task automatic test_retry();
    bit ok, ps;
    acc_log.delete();
    resp_q.push_back('{K_ACK, 0, 8'h20});
    resp_q.push_back('{K_RTY, 1, 8'h00});
    send_byte(8'h43, ok);
    wait_ready(100, ok, ps);
    total++;
    if (!ok || err_flag !== 1'b0) begin bad++; $display("FAIL retry_done: ready=%b err=%b required 1 0", ok, err_flag); end
    total++;
    if (acc_log.size() != 3 || acc_log[1].adr !== 3'd0 || acc_log[1].dat !== 8'h43 ||
        acc_log[2].adr !== 3'd0 || acc_log[2].dat !== 8'h43 || acc_log[2].we !== 1'b1 || acc_log[2].gap != 1) begin
      bad++; $display("FAIL retry_repeat: got %0d accesses required read + two identical writes of 43 one idle apart",
                      acc_log.size());
    end
  endtask

  task automatic test_random();
    bit ok, ps;
    for (int it = 0; it < 20; it++) begin
      logic [7:0] b, r;
      int busy, nexp;
      bit use_rty, match;
      b = 8'($urandom);
      busy = $urandom_range(0, 3);
      use_rty = ($urandom_range(0, 3) == 0);
      acc_log.delete();
      for (int k = 0; k < busy; k++) begin
        r = 8'($urandom) & 8'hDF;
        resp_q.push_back('{K_ACK, int'($urandom_range(0, 2)), r});
      end
      r = 8'($urandom) | 8'h20;
      resp_q.push_back('{K_ACK, int'($urandom_range(0, 2)), r});
      if (use_rty) resp_q.push_back('{K_RTY, int'($urandom_range(0, 2)), 8'h00});
      resp_q.push_back('{K_ACK, int'($urandom_range(0, 2)), 8'h00});
      send_byte(b, ok);
      wait_ready(200, ok, ps);
      nexp = busy + 2 + (use_rty ? 1 : 0);
      match = ok && (acc_log.size() == nexp) && (err_flag === 1'b0);
      if (match) begin
        for (int k = 0; k < nexp; k++) begin
          if (k <= busy) begin
            if (acc_log[k].adr !== 3'd5 || acc_log[k].we !== 1'b0) match = 1'b0;
          end else begin
            if (acc_log[k].adr !== 3'd0 || acc_log[k].dat !== b || acc_log[k].we !== 1'b1) match = 1'b0;
          end
          if (k > 0 && acc_log[k].gap != 1) match = 1'b0;
        end
      end
      total++;
      if (!match) begin
        bad++; $display("FAIL random_it%0d: byte=%h busy=%0d rty=%0d got %0d accesses required %0d",
                        it, b, busy, use_rty, acc_log.size(), nexp);
      end
    end
  endtask

  task automatic test_err_priority();
    bit ok, ps;
    acc_log.delete();
    total++;
    if (err_flag !== 1'b0) begin bad++; $display("FAIL err_pre: got %b required 0", err_flag); end
    resp_q.push_back('{K_ACK, 0, 8'h20});
    resp_q.push_back('{K_ERRACK, 0, 8'h00});
    send_byte(8'h44, ok);
    wait_ready(100, ok, ps);
    repeat (4) @(negedge clk);
    total++;
    if (!ok || err_flag !== 1'b1 || acc_log.size() != 2) begin
      bad++; $display("FAIL err_over_ack: ready=%b err=%b accesses=%0d required 1 1 2", ok, err_flag, acc_log.size());
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok, ps;
    int n = 0;
    acc_log.delete();
    resp_q.push_back('{K_ACK, 0, 8'h20});
    resp_q.push_back('{K_SILENT, 0, 8'h00});
    send_byte(8'h45, ok);
    while (!(stb_o && we_o) && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!(stb_o && we_o)) begin bad++; $display("FAIL midwrite_reach: stb=%b we=%b required 1 1", stb_o, we_o); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({stb_o, cyc_o, we_o, adr_o, dat_o, tx_ready, init_done, err_flag} !== '0) begin
      bad++; $display("FAIL midwrite_reset_force: got %b required all zero",
                      {stb_o, cyc_o, we_o, adr_o, dat_o, tx_ready, init_done, err_flag});
    end
    release_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (stb_o !== 1'b1 || adr_o !== 3'd3 || dat_o !== (8'h80 | LCR)) begin
      bad++; $display("FAIL midwrite_restart: stb=%b adr=%0d dat=%h required 1 3 %h", stb_o, adr_o, dat_o, 8'h80 | LCR);
    end
    wait_init(200, ok, ps);
    total++;
    if (!ok || acc_log.size() != 6 || err_flag !== 1'b0) begin
      bad++; $display("FAIL midwrite_reinit: done=%b accesses=%0d err=%b required 1 6 0", ok, acc_log.size(), err_flag);
    end
  endtask

  task automatic test_timeout();
    bit ok, ps;
    @(negedge clk);
    acc_log.delete();
    resp_q.push_back('{K_ACK, 0, 8'h20});
    resp_q.push_back('{K_SILENT, 0, 8'h00});
    send_byte(8'h46, ok);
    wait_ready(100, ok, ps);
    total++;
    if (!ok || err_flag !== 1'b1) begin bad++; $display("FAIL timeout_flags: ready=%b err=%b required 1 1", ok, err_flag); end
    total++;
    if (acc_log.size() != 2 || acc_log[1].dur != int'(TMO)) begin
      bad++; $display("FAIL timeout_stb_cycles: accesses=%0d dur=%0d required 2 %0d",
                      acc_log.size(), (acc_log.size() > 1) ? acc_log[1].dur : -1, TMO);
    end
  endtask

  task automatic test_err_rty();
    bit ok, ps;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    wait_init(200, ok, ps);
    @(negedge clk);
    acc_log.delete();
    total++;
    if (err_flag !== 1'b0) begin bad++; $display("FAIL err_cleared_by_reset: got %b required 0", err_flag); end
    resp_q.push_back('{K_ACK, 0, 8'h20});
    resp_q.push_back('{K_ERRRTY, 0, 8'h00});
    send_byte(8'h47, ok);
    wait_ready(100, ok, ps);
    repeat (4) @(negedge clk);
    total++;
    if (!ok || err_flag !== 1'b1 || acc_log.size() != 2) begin
      bad++; $display("FAIL err_over_rty: ready=%b err=%b accesses=%0d required 1 1 2", ok, err_flag, acc_log.size());
    end
  endtask

  task automatic test_protocol();
    total++;
    if (proto_viol != 0) begin bad++; $display("FAIL bus_protocol: violations=%0d required 0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_send_41();
    test_poll_busy();
    test_retry();
    test_random();
    test_err_priority();
    test_reset_mid_write();
    test_timeout();
    test_err_rty();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
